matvec_mult_stream: RTL

//  Streaming NxN-matrix by N-vector multiplier for the pixel transform path (M * pixel^T).

---
 rtl/matvec_mult_stream_pkg.sv | 27 ++
 rtl/matvec_mult_stream_mac_lane.sv | 102 ++++++++++
 rtl/matvec_mult_stream.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/matvec_mult_stream_pkg.sv
// Shared definitions for the streaming matrix-vector multiplier: FSM encoding,
// default geometry and a ceil-log2 helper for counter sizing.
package matrixmult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int DEF_N      = 4;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 34;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/matvec_mult_stream_mac_lane.sv
// Two-stage multiply-accumulate lane: stage 1 registers the extended product,
// stage 2 accumulates a row and emits the row sum on the tagged last column.
module mac_lane
  import matrixmult_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter bit SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              in_valid,
  input  logic              first,
  input  logic              last,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [ACC_W-1:0]  sum,
  output logic              sum_valid
);

  localparam int PW = 2 * DATA_W;

  logic [PW-1:0]    ext_a_s;
  logic [PW-1:0]    ext_b_s;
  logic [PW-1:0]    prod_s;
  logic [ACC_W-1:0] prod_ext_s;
  logic [ACC_W-1:0] acc_next_s;
  logic [ACC_W-1:0] p_r;
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] sum_r;
  logic             p_valid_r;
  logic             p_first_r;
  logic             p_last_r;
  logic             sum_valid_r;

  // Low 2*DATA_W bits of the product are exact for both signednesses once operands are extended.
  always_comb begin
    if (SIGNED) begin
      ext_a_s = {{DATA_W{in_a[DATA_W-1]}}, in_a};
      ext_b_s = {{DATA_W{in_b[DATA_W-1]}}, in_b};
    end else begin
      ext_a_s = {{DATA_W{1'b0}}, in_a};
      ext_b_s = {{DATA_W{1'b0}}, in_b};
    end
    prod_s = ext_a_s * ext_b_s;
  end

  if (ACC_W > PW) begin : g_ext
    assign prod_ext_s = {{(ACC_W - PW){SIGNED & prod_s[PW-1]}}, prod_s};
  end else begin : g_trunc
    assign prod_ext_s = prod_s[ACC_W-1:0];
  end

  assign acc_next_s = p_first_r ? p_r : (acc_r + p_r);

  // Stage 1: product register with its valid/first/last tags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_r       <= '0;
      p_valid_r <= 1'b0;
      p_first_r <= 1'b0;
      p_last_r  <= 1'b0;
    end else if (clr) begin
      p_r       <= '0;
      p_valid_r <= 1'b0;
      p_first_r <= 1'b0;
      p_last_r  <= 1'b0;
    end else begin
      p_valid_r <= in_valid;
      if (in_valid) begin
        p_r       <= prod_ext_s;
        p_first_r <= first;
        p_last_r  <= last;
      end
    end
  end

  // Stage 2: accumulate; bubbles leave acc untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r       <= '0;
      sum_r       <= '0;
      sum_valid_r <= 1'b0;
    end else if (clr) begin
      acc_r       <= '0;
      sum_valid_r <= 1'b0;
    end else begin
      sum_valid_r <= p_valid_r & p_last_r;
      if (p_valid_r) begin
        acc_r <= acc_next_s;
        if (p_last_r) begin
          sum_r <= acc_next_s;
        end
      end
    end
  end

  assign sum       = sum_r;
  assign sum_valid = sum_valid_r;

endmodule

// File: rtl/matvec_mult_stream.sv
// Streaming NxN matrix by N-vector multiplier: loads row-major pairs, buffers
// the N row sums, then drains them through a valid/ready result port.
module matvec_mult_stream
  import matrixmult_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter bit SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_last,
  output logic              busy,
  output logic              done
);

  localparam int            CW       = (clog2(N) < 1) ? 1 : clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  state_t           state_r;
  state_t           state_next_s;
  logic [CW-1:0]    col_r;
  logic [CW-1:0]    row_r;
  logic [CW-1:0]    wr_idx_r;
  logic [CW-1:0]    rd_idx_r;
  logic             flush_cnt_r;
  logic [ACC_W-1:0] buffer_r [N];

  logic             accept_s;
  logic             res_xfer_s;
  logic             last_pair_s;
  logic [ACC_W-1:0] mac_sum_s;
  logic             mac_sum_valid_s;

  // A start on the same cycle as a handshake wins; the handshake is dropped.
  assign accept_s    = in_valid & (state_r == ST_LOAD) & ~start;
  assign res_xfer_s  = res_ready & (state_r == ST_DRAIN) & ~start;
  assign last_pair_s = accept_s & (col_r == LAST_IDX) & (row_r == LAST_IDX);

  mac_lane #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .clr       (start),
    .in_valid  (accept_s),
    .first     (col_r == {CW{1'b0}}),
    .last      (col_r == LAST_IDX),
    .in_a      (in_a),
    .in_b      (in_b),
    .sum       (mac_sum_s),
    .sum_valid (mac_sum_valid_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; start overrides every state.
  always_comb begin
    state_next_s = state_r;
    if (start) begin
      state_next_s = ST_LOAD;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_next_s = ST_IDLE;
        end
        ST_LOAD: begin
          if (last_pair_s) state_next_s = ST_FLUSH;
          else             state_next_s = ST_LOAD;
        end
        ST_FLUSH: begin
          if (flush_cnt_r) state_next_s = ST_DRAIN;
          else             state_next_s = ST_FLUSH;
        end
        ST_DRAIN: begin
          if (res_xfer_s && (rd_idx_r == LAST_IDX)) state_next_s = ST_IDLE;
          else                                      state_next_s = ST_DRAIN;
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // Load counters, flush timer, result buffer writes and drain pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_r       <= '0;
      row_r       <= '0;
      wr_idx_r    <= '0;
      rd_idx_r    <= '0;
      flush_cnt_r <= 1'b0;
      for (int i = 0; i < N; i++) buffer_r[i] <= '0;
    end else if (start) begin
      col_r       <= '0;
      row_r       <= '0;
      wr_idx_r    <= '0;
      rd_idx_r    <= '0;
      flush_cnt_r <= 1'b0;
      for (int i = 0; i < N; i++) buffer_r[i] <= '0;
    end else begin
      if (accept_s) begin
        if (col_r == LAST_IDX) begin
          col_r <= '0;
          row_r <= (row_r == LAST_IDX) ? {CW{1'b0}} : row_r + 1'b1;
        end else begin
          col_r <= col_r + 1'b1;
        end
      end
      if (mac_sum_valid_s) begin
        buffer_r[wr_idx_r] <= mac_sum_s;
        wr_idx_r           <= (wr_idx_r == LAST_IDX) ? {CW{1'b0}} : wr_idx_r + 1'b1;
      end
      // Two-cycle FLUSH: the toggle reaches 1 on the second FLUSH cycle.
      flush_cnt_r <= (state_r == ST_FLUSH) ? ~flush_cnt_r : 1'b0;
      if (res_xfer_s) begin
        rd_idx_r <= (rd_idx_r == LAST_IDX) ? {CW{1'b0}} : rd_idx_r + 1'b1;
      end
    end
  end

  assign in_ready  = (state_r == ST_LOAD);
  assign busy      = (state_r != ST_IDLE);
  assign res_valid = (state_r == ST_DRAIN);
  assign res_last  = (state_r == ST_DRAIN) & (rd_idx_r == LAST_IDX);
  assign res_data  = (state_r == ST_DRAIN) ? buffer_r[rd_idx_r] : {ACC_W{1'b0}};
  assign done      = res_xfer_s & (rd_idx_r == LAST_IDX);

endmodule
